arcino_multdiv_ctrl: RTL and testbench

ARCINO_MULTDIV_CTRL -- requirements
Module: arcino_multdiv_ctrl

---
 rtl/arcino_multdiv_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_arcino_multdiv_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcino_multdiv_ctrl.sv
// Mult/div sequencing controller between the ID stage and a multi-cycle
// multiplier/divider. It captures one operation and holds its operands, drives
// the matching unit enable until the unit reports done, then hands the result
// to the register file through a writeback handshake. A watchdog aborts an
// operation that never completes.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where
// valid and ready are both high. The request side transfers on
// req_valid_i & req_ready_o. The writeback side transfers on
// wb_valid_o & wb_ready_i. A valid, once raised, holds its payload stable
// until the transfer edge, unless a flush withdraws it.
//
// Timing: the cycle right after capture is a launch cycle. The captured
// operands become visible to the unit in that cycle, and the enable is raised
// at the end of it. md_ready_i only counts while an enable is high.
module arcino_multdiv_ctrl #(
    parameter int unsigned RegAddrW   = 5,
    parameter int unsigned WdogCycles = 40
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    // request from ID
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_op_i,
    input  logic [1:0]          req_signed_i,
    input  logic [31:0]         req_a_i,
    input  logic [31:0]         req_b_i,
    input  logic [RegAddrW-1:0] req_rd_i,
    input  logic                flush_i,
    // multiplier/divider side
    output logic                mult_en_o,
    output logic                div_en_o,
    output logic [1:0]          operator_o,
    output logic [1:0]          signed_mode_o,
    output logic [31:0]         op_a_o,
    output logic [31:0]         op_b_o,
    input  logic [31:0]         md_result_i,
    input  logic                md_ready_i,
    // writeback
    output logic                wb_valid_o,
    output logic [RegAddrW-1:0] wb_rd_o,
    output logic [31:0]         wb_data_o,
    input  logic                wb_ready_i,
    // status
    output logic                busy_o,
    output logic                wdog_err_o,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WB    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    state_e              state_q;
    md_op_e              op_q;
    logic [1:0]          signed_q;
    logic [31:0]         a_q;
    logic [31:0]         b_q;
    logic [RegAddrW-1:0] rd_q;
    logic [31:0]         wb_data_q;
    logic                mult_en_q;
    logic                div_en_q;
    logic [5:0]          wdog_cnt_q;
    logic [5:0]          wdog_cnt_d;
    logic                wdog_err_q;

    logic capture;
    logic en_active;
    logic is_div_op;
    logic wdog_hit;

    assign capture   = (state_q == ST_IDLE) && req_valid_i && !flush_i;
    assign en_active = mult_en_q || div_en_q;
    assign is_div_op = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);

    // Saturating count of enabled cycles; a timeout fires on the cycle that reaches the limit.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (en_active && (wdog_cnt_q != 6'h3f)) begin
            wdog_cnt_d = wdog_cnt_q + 6'd1;
        end
    end

    assign wdog_hit = en_active && !md_ready_i && (wdog_cnt_d == 6'(WdogCycles));

    // Controller FSM together with all captured and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            op_q       <= MD_OP_MULL;
            signed_q   <= 2'b00;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            rd_q       <= '0;
            wb_data_q  <= 32'd0;
            mult_en_q  <= 1'b0;
            div_en_q   <= 1'b0;
            wdog_cnt_q <= 6'd0;
            wdog_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        op_q       <= md_op_e'(req_op_i);
                        signed_q   <= req_signed_i;
                        a_q        <= req_a_i;
                        b_q        <= req_b_i;
                        rd_q       <= req_rd_i;
                        wdog_cnt_q <= 6'd0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en_active) begin
                        // Launch cycle: the unit has not started yet, so a flush can simply abandon it.
                        if (flush_i) begin
                            state_q <= ST_IDLE;
                        end else begin
                            mult_en_q <= !is_div_op;
                            div_en_q  <= is_div_op;
                        end
                    end else begin
                        wdog_cnt_q <= wdog_cnt_d;
                        if (md_ready_i) begin
                            mult_en_q <= 1'b0;
                            div_en_q  <= 1'b0;
                            if (flush_i) begin
                                state_q <= ST_IDLE;
                            end else begin
                                wb_data_q <= md_result_i;
                                state_q   <= ST_WB;
                            end
                        end else if (wdog_hit) begin
                            mult_en_q  <= 1'b0;
                            div_en_q   <= 1'b0;
                            wdog_err_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else if (flush_i) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Keep the unit enabled until it finishes so it returns to its own idle state.
                    wdog_cnt_q <= wdog_cnt_d;
                    if (md_ready_i) begin
                        mult_en_q <= 1'b0;
                        div_en_q  <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (wdog_hit) begin
                        mult_en_q  <= 1'b0;
                        div_en_q   <= 1'b0;
                        wdog_err_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_WB: begin
                    if (wb_ready_i || flush_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o   = (state_q == ST_IDLE) && !flush_i;
    assign busy_o        = (state_q != ST_IDLE) || (req_valid_i && req_ready_o && !flush_i);
    assign mult_en_o     = mult_en_q;
    assign div_en_o      = div_en_q;
    assign operator_o    = op_q;
    assign signed_mode_o = signed_q;
    assign op_a_o        = a_q;
    assign op_b_o        = b_q;
    assign wb_valid_o    = (state_q == ST_WB);
    assign wb_rd_o       = rd_q;
    assign wb_data_o     = wb_data_q;
    assign wdog_err_o    = wdog_err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_arcino_multdiv_ctrl.sv
// Directed bench for arcino_multdiv_ctrl. Each task drives one scenario and
// checks the outputs against hand-computed values. Inputs change and outputs
// are sampled 1 ns after the rising edge.
module tb_arcino_multdiv_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [1:0]  req_signed;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    logic        flush;
    logic        mult_en;
    logic        div_en;
    logic [1:0]  operator;
    logic [1:0]  signed_mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] md_result;
    logic        md_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        busy;
    logic        wdog_err;
    logic [1:0]  state;

    int checks;
    int failures;

    arcino_multdiv_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_signed_i (req_signed),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_rd_i     (req_rd),
        .flush_i      (flush),
        .mult_en_o    (mult_en),
        .div_en_o     (div_en),
        .operator_o   (operator),
        .signed_mode_o(signed_mode),
        .op_a_o       (op_a),
        .op_b_o       (op_b),
        .md_result_i  (md_result),
        .md_ready_i   (md_ready),
        .wb_valid_o   (wb_valid),
        .wb_rd_o      (wb_rd),
        .wb_data_o    (wb_data),
        .wb_ready_i   (wb_ready),
        .busy_o       (busy),
        .wdog_err_o   (wdog_err),
        .state_o      (state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one request while in IDLE; returns 1 ns after the capture edge.
    task automatic capture(input logic [1:0] op, input logic [1:0] sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_op     = op;
        req_signed = sg;
        req_a      = a;
        req_b      = b;
        req_rd     = rd;
        tick();
        req_valid = 1'b0;
    endtask

    // Starting 1 ns after a capture edge, model a unit that raises md_ready
    // in cycle lat after capture, then check the writeback that follows.
    task automatic run_to_wb(input int lat, input logic [31:0] res, input int exp_m, input int exp_d,
                             input logic [4:0] exp_rd, input logic [31:0] exp_a, input logic [31:0] exp_b,
                             input logic [1:0] exp_op, input logic [1:0] exp_sg, input string name);
        int mcnt = 0;
        int dcnt = 0;
        int wb_at = -1;
        bit both = 1'b0;
        bit hold_ok = 1'b1;
        for (int t = 0; t <= lat + 4; t++) begin
            if (mult_en) mcnt++;
            if (div_en) dcnt++;
            if (mult_en && div_en) both = 1'b1;
            if (op_a !== exp_a || op_b !== exp_b || operator !== exp_op || signed_mode !== exp_sg) hold_ok = 1'b0;
            if (wb_valid) begin
                wb_at = t;
                break;
            end
            md_ready  = (t == lat);
            md_result = (t == lat) ? res : 32'hDEAD_BEEF;
            tick();
        end
        md_ready = 1'b0;
        checks++;
        if (wb_at != lat + 1) begin
            failures++;
            $display("FAIL %s_latency got=%0d want=%0d", name, wb_at, lat + 1);
        end
        checks++;
        if (mcnt != exp_m || dcnt != exp_d) begin
            failures++;
            $display("FAIL %s_enables mult=%0d div=%0d want mult=%0d div=%0d", name, mcnt, dcnt, exp_m, exp_d);
        end
        checks++;
        if (both || !hold_ok) begin
            failures++;
            $display("FAIL %s_hold both_en=%0b operands_held=%0b want both_en=0 operands_held=1", name, both, hold_ok);
        end
        checks++;
        if (wb_rd !== exp_rd || wb_data !== res) begin
            failures++;
            $display("FAIL %s_wb rd=%0d data=%h want rd=%0d data=%h", name, wb_rd, wb_data, exp_rd, res);
        end
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1 || mult_en !== 1'b0 || div_en !== 1'b0) begin
            failures++;
            $display("FAIL %s_wb_state ready=%b busy=%b men=%b den=%b want 0 1 0 0", name, req_ready, busy, mult_en, div_en);
        end
    endtask

    // Complete the writeback handshake and check the return to IDLE.
    task automatic release_wb(input string name);
        wb_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_ready_on_wb_cycle got=%b want=0", name, req_ready);
        end
        tick();
        wb_ready = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || state !== 2'd0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_after_wb wb_valid=%b state=%0d ready=%b want 0 0 1", name, wb_valid, state, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 2'd0; req_signed = 2'd0; req_a = 32'd0; req_b = 32'd0; req_rd = 5'd0;
        flush = 1'b0; md_result = 32'd0; md_ready = 1'b0; wb_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (req_ready !== 1'b1 || mult_en !== 1'b0 || div_en !== 1'b0 || wb_valid !== 1'b0 ||
            busy !== 1'b0 || wdog_err !== 1'b0 || state !== 2'd0) begin
            failures++;
            $display("FAIL reset_ctrl ready=%b men=%b den=%b wbv=%b busy=%b err=%b state=%0d", req_ready, mult_en,
                     div_en, wb_valid, busy, wdog_err, state);
        end
        checks++;
        if (op_a !== 32'd0 || op_b !== 32'd0 || operator !== 2'd0 || signed_mode !== 2'd0 ||
            wb_rd !== 5'd0 || wb_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_data a=%h b=%h op=%0d sg=%0d rd=%0d data=%h want all 0", op_a, op_b, operator,
                     signed_mode, wb_rd, wb_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mull();
        capture(2'd0, 2'b00, 32'd7, 32'd6, 5'd5);
        run_to_wb(2, 32'h0000_002A, 2, 0, 5'd5, 32'd7, 32'd6, 2'd0, 2'b00, "mull");
        release_wb("mull");
    endtask

    task automatic test_mulh();
        // 0x12345678 * 0x100 = 0x12_3456_7800, upper word 0x12
        capture(2'd1, 2'b00, 32'h1234_5678, 32'h0000_0100, 5'd17);
        run_to_wb(4, 32'h0000_0012, 4, 0, 5'd17, 32'h1234_5678, 32'h0000_0100, 2'd1, 2'b00, "mulh");
        release_wb("mulh");
    endtask

    task automatic test_div();
        capture(2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd3);
        run_to_wb(36, 32'hFFFF_FFFD, 0, 36, 5'd3, 32'hFFFF_FFF9, 32'd2, 2'd2, 2'b11, "div");
        release_wb("div");
    endtask

    task automatic test_flush_run();
        int dcnt = 0;
        bit wb_seen = 1'b0;
        capture(2'd3, 2'b11, 32'd100, 32'd7, 5'd9);
        for (int t = 0; t <= 40; t++) begin
            if (div_en) dcnt++;
            if (wb_valid) wb_seen = 1'b1;
            if (t == 4) begin
                checks++;
                if (state !== 2'd2) begin
                    failures++;
                    $display("FAIL flush_run_drain state=%0d want=2", state);
                end
            end
            if (t == 37) break;
            flush    = (t == 3);
            md_ready = (t == 36);
            md_result = 32'd2;
            tick();
        end
        flush = 1'b0;
        md_ready = 1'b0;
        checks++;
        if (dcnt != 36 || mult_en !== 1'b0 || div_en !== 1'b0) begin
            failures++;
            $display("FAIL flush_run_enable div_cycles=%0d men=%b den=%b want 36 0 0", dcnt, mult_en, div_en);
        end
        checks++;
        if (wb_seen || state !== 2'd0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_run_end wb_seen=%b state=%0d ready=%b want 0 0 1", wb_seen, state, req_ready);
        end
    endtask

    task automatic test_flush_wb();
        capture(2'd0, 2'b01, 32'd3, 32'd4, 5'd8);
        run_to_wb(2, 32'd12, 2, 0, 5'd8, 32'd3, 32'd4, 2'd0, 2'b01, "flush_wb");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || state !== 2'd0) begin
            failures++;
            $display("FAIL flush_wb wb_valid=%b state=%0d want 0 0", wb_valid, state);
        end
    endtask

    task automatic test_flush_idle();
        req_valid = 1'b1;
        req_a = 32'h5555_0000;
        flush = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_comb ready=%b busy=%b want 0 0", req_ready, busy);
        end
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || op_a === 32'h5555_0000 || req_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle_blocked state=%0d op_a=%h ready=%b busy=%b want 0 !=55550000 1 1", state, op_a,
                     req_ready, busy);
        end
        req_valid = 1'b0;
        md_ready = 1'b1;
        tick();
        md_ready = 1'b0;
        checks++;
        if (state !== 2'd0 || wb_valid !== 1'b0 || mult_en !== 1'b0 || div_en !== 1'b0) begin
            failures++;
            $display("FAIL md_ready_idle state=%0d wbv=%b men=%b den=%b want 0 0 0 0", state, wb_valid, mult_en, div_en);
        end
    endtask

    task automatic test_back_to_back();
        bit stable = 1'b1;
        capture(2'd0, 2'b00, 32'd7, 32'd6, 5'd5);
        run_to_wb(2, 32'h0000_002A, 2, 0, 5'd5, 32'd7, 32'd6, 2'd0, 2'b00, "b2b_first");
        req_valid = 1'b1; req_op = 2'd1; req_signed = 2'b10; req_a = 32'd3; req_b = 32'd9; req_rd = 5'd9;
        md_ready = 1'b1;
        md_result = 32'h0BAD_0BAD;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h0000_002A || req_ready !== 1'b0 ||
                op_a !== 32'd7) stable = 1'b0;
            tick();
        end
        md_ready = 1'b0;
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL b2b_wb_stall wb outputs or ready changed while wb_ready low (stable=0 want 1)");
        end
        release_wb("b2b");
        checks++;
        if (op_a !== 32'd7 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_not_yet op_a=%h busy=%b want 00000007 1", op_a, busy);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (state !== 2'd1 || op_a !== 32'd3 || op_b !== 32'd9 || operator !== 2'd1 || signed_mode !== 2'b10) begin
            failures++;
            $display("FAIL b2b_second_capture state=%0d a=%h b=%h op=%0d sg=%0d want 1 3 9 1 2", state, op_a, op_b,
                     operator, signed_mode);
        end
        run_to_wb(4, 32'd0, 4, 0, 5'd9, 32'd3, 32'd9, 2'd1, 2'b10, "b2b_second");
        release_wb("b2b_second");
    endtask

    task automatic test_wdog();
        int dcnt = 0;
        int idle_at = -1;
        bit wb_seen = 1'b0;
        capture(2'd2, 2'b00, 32'd50, 32'd5, 5'd4);
        for (int t = 0; t <= 60; t++) begin
            if (div_en) dcnt++;
            if (wb_valid) wb_seen = 1'b1;
            if (t > 0 && state === 2'd0) begin
                idle_at = t;
                break;
            end
            tick();
        end
        checks++;
        if (dcnt != 40 || idle_at != 41) begin
            failures++;
            $display("FAIL wdog_timing enabled=%0d idle_at=%0d want 40 41", dcnt, idle_at);
        end
        checks++;
        if (wdog_err !== 1'b1 || wb_seen || div_en !== 1'b0) begin
            failures++;
            $display("FAIL wdog_flag err=%b wb_seen=%b den=%b want 1 0 0", wdog_err, wb_seen, div_en);
        end
        tick();
        checks++;
        if (wdog_err !== 1'b1) begin
            failures++;
            $display("FAIL wdog_sticky err=%b want 1", wdog_err);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wdog_err !== 1'b0) begin
            failures++;
            $display("FAIL wdog_reset_clear err=%b want 0", wdog_err);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        capture(2'd0, 2'b11, 32'hCAFE_F00D, 32'h0000_1234, 5'd21);
        for (int t = 0; t < 10; t++) tick();
        checks++;
        if (mult_en !== 1'b1 || state !== 2'd1) begin
            failures++;
            $display("FAIL async_pre men=%b state=%0d want 1 1", mult_en, state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mult_en !== 1'b0 || div_en !== 1'b0 || state !== 2'd0 || req_ready !== 1'b1 || busy !== 1'b0 ||
            wb_valid !== 1'b0 || op_a !== 32'd0 || op_b !== 32'd0 || operator !== 2'd0 || signed_mode !== 2'd0 ||
            wb_rd !== 5'd0 || wb_data !== 32'd0 || wdog_err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset men=%b den=%b state=%0d ready=%b busy=%b a=%h rd=%0d data=%h", mult_en, div_en,
                     state, req_ready, busy, op_a, wb_rd, wb_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_mull();
        test_mulh();
        test_div();
        test_flush_run();
        test_flush_wb();
        test_flush_idle();
        test_back_to_back();
        test_wdog();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
